robot_motion_ctrl: RTL and testbench

//  Motion/cleaning sequencer for the pipe-cleaning robot. Consumes already-debounced

---
 rtl/robot_motion_ctrl_if.sv | 25 ++
 rtl/robot_motion_ctrl.sv | 137 +++++++++++++
 tb/tb_robot_motion_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/robot_motion_ctrl_if.sv
// Sensor-to-actuator bundle for the pipe-cleaning robot sequencer.
// The slave side is the motion controller: it reads the debounced sensor levels
// and drives the actuator enables plus the fault and debug state code.
// The master side is whatever supplies the sensors and watches the actuators.
interface robot_motion_ctrl_if;
  logic       go;
  logic       head;
  logic       under;
  logic       barrier;
  logic       avanca;
  logic       gira;
  logic       remove;
  logic       fault;
  logic [2:0] state;

  modport master (
    output go, head, under, barrier,
    input  avanca, gira, remove, fault, state
  );

  modport slave (
    input  go, head, under, barrier,
    output avanca, gira, remove, fault, state
  );
endinterface

// File: rtl/robot_motion_ctrl.sv
// Motion/cleaning sequencer for the pipe-cleaning robot.
// Drives forward, turn and brush enables from debounced sensor levels.
// Turn and clean actions run for a fixed number of cycles.
// An action that keeps failing escalates to a sticky fault that only reset clears.
// Actuator outputs are decoded from the state register alone, so the design has a
// one-cycle latency from sensor change to actuator change.
module robot_motion_ctrl #(
  parameter int CNT_W        = 8,
  parameter int TURN_CYCLES  = 4,
  parameter int CLEAN_CYCLES = 8,
  parameter int MAX_TURNS    = 3,
  parameter int MAX_CLEANS   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  robot_motion_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_STOP  = 3'd0,
    ST_FWD   = 3'd1,
    ST_TURN  = 3'd2,
    ST_CLEAN = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAN_LOAD  = CNT_W'(CLEAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMER_ZERO  = '0;
  localparam logic [CNT_W-1:0] TIMER_ONE   = CNT_W'(1);
  localparam logic [2:0]       TURN_LIMIT  = 3'(MAX_TURNS);
  localparam logic [2:0]       CLEAN_LIMIT = 3'(MAX_CLEANS);

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic [2:0]       r_turnCnt;
  logic [2:0]       r_cleanCnt;

  state_t           w_state;
  logic [CNT_W-1:0] w_timer;
  logic [2:0]       w_turnCnt;
  logic [2:0]       w_cleanCnt;

  // State, timer and retry counters register; reset dominates everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_STOP;
      r_timer    <= '0;
      r_turnCnt  <= '0;
      r_cleanCnt <= '0;
    end else begin
      r_state    <= w_state;
      r_timer    <= w_timer;
      r_turnCnt  <= w_turnCnt;
      r_cleanCnt <= w_cleanCnt;
    end
  end

  // Next-state logic: floor loss beats operator stop, which beats normal sequencing.
  always_comb begin
    w_state    = r_state;
    w_timer    = r_timer;
    w_turnCnt  = r_turnCnt;
    w_cleanCnt = r_cleanCnt;

    if (r_state == ST_FAULT) begin
      w_state = ST_FAULT;
    end else if (!bus.under) begin
      w_state = ST_FAULT;
    end else if (!bus.go) begin
      w_state    = ST_STOP;
      w_timer    = '0;
      w_turnCnt  = '0;
      w_cleanCnt = '0;
    end else begin
      case (r_state)
        ST_STOP: begin
          w_state    = ST_FWD;
          w_timer    = '0;
          w_turnCnt  = '0;
          w_cleanCnt = '0;
        end
        ST_FWD: begin
          if (bus.barrier) begin
            w_state    = ST_CLEAN;
            w_timer    = CLEAN_LOAD;
            w_cleanCnt = 3'd1;
          end else if (bus.head) begin
            w_state   = ST_TURN;
            w_timer   = TURN_LOAD;
            w_turnCnt = 3'd1;
          end else begin
            w_turnCnt  = '0;
            w_cleanCnt = '0;
          end
        end
        ST_TURN: begin
          if (r_timer != TIMER_ZERO) begin
            w_timer = r_timer - TIMER_ONE;
          end else if (!bus.head) begin
            w_state   = ST_FWD;
            w_turnCnt = '0;
          end else if (r_turnCnt < TURN_LIMIT) begin
            w_timer   = TURN_LOAD;
            w_turnCnt = (r_turnCnt == 3'd7) ? 3'd7 : r_turnCnt + 3'd1;
          end else begin
            w_state = ST_FAULT;
          end
        end
        ST_CLEAN: begin
          if (r_timer != TIMER_ZERO) begin
            w_timer = r_timer - TIMER_ONE;
          end else if (!bus.barrier) begin
            w_state    = ST_FWD;
            w_cleanCnt = '0;
          end else if (r_cleanCnt < CLEAN_LIMIT) begin
            w_timer    = CLEAN_LOAD;
            w_cleanCnt = (r_cleanCnt == 3'd7) ? 3'd7 : r_cleanCnt + 3'd1;
          end else begin
            w_state = ST_FAULT;
          end
        end
        default: begin
          w_state = ST_STOP;
          w_timer = '0;
        end
      endcase
    end
  end

  assign bus.avanca = (r_state == ST_FWD);
  assign bus.gira   = (r_state == ST_TURN);
  assign bus.remove = (r_state == ST_CLEAN);
  assign bus.fault  = (r_state == ST_FAULT);
  assign bus.state  = r_state;

endmodule

// File: tb/tb_robot_motion_ctrl.sv
// Self-checking bench for robot_motion_ctrl: directed scenarios followed by a
// randomized sensor soak, all compared against a behavioural model of the robot.
module tb_robot_motion_ctrl;

  localparam int TURN_CYCLES  = 4;
  localparam int CLEAN_CYCLES = 8;
  localparam int MAX_TURNS    = 3;
  localparam int MAX_CLEANS   = 3;

  localparam int M_STOP  = 0;
  localparam int M_FWD   = 1;
  localparam int M_TURN  = 2;
  localparam int M_CLEAN = 3;
  localparam int M_FAULT = 4;

  logic clk;
  logic reset;

  robot_motion_ctrl_if bus ();

  robot_motion_ctrl #(
    .CNT_W        (8),
    .TURN_CYCLES  (TURN_CYCLES),
    .CLEAN_CYCLES (CLEAN_CYCLES),
    .MAX_TURNS    (MAX_TURNS),
    .MAX_CLEANS   (MAX_CLEANS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: current activity, cycles left in the running attempt,
  // and how many attempts of that activity have been made in a row.
  int mMode  = M_STOP;
  int mLeft  = 0;
  int mTries = 0;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelStep(input bit rstN, input bit g, input bit h, input bit u, input bit b);
    if (!rstN) begin
      mMode = M_STOP; mLeft = 0; mTries = 0;
    end else if (mMode == M_FAULT) begin
      mMode = M_FAULT;
    end else if (!u) begin
      mMode = M_FAULT;
    end else if (!g) begin
      mMode = M_STOP; mTries = 0;
    end else begin
      case (mMode)
        M_STOP: mMode = M_FWD;
        M_FWD: begin
          if (b) begin
            mMode = M_CLEAN; mLeft = CLEAN_CYCLES; mTries = 1;
          end else if (h) begin
            mMode = M_TURN; mLeft = TURN_CYCLES; mTries = 1;
          end
        end
        M_TURN: begin
          if (mLeft > 1) mLeft--;
          else if (!h) mMode = M_FWD;
          else if (mTries < MAX_TURNS) begin mTries++; mLeft = TURN_CYCLES; end
          else mMode = M_FAULT;
        end
        M_CLEAN: begin
          if (mLeft > 1) mLeft--;
          else if (!b) mMode = M_FWD;
          else if (mTries < MAX_CLEANS) begin mTries++; mLeft = CLEAN_CYCLES; end
          else mMode = M_FAULT;
        end
        default: mMode = M_STOP;
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the full output vector with the model, plus the one-actuator rule.
  task automatic checkOutput(input string tag);
    logic [7:0] obs;
    logic [7:0] exp;
    obs = {1'b0, bus.state, bus.fault, bus.remove, bus.gira, bus.avanca};
    exp = {1'b0, 3'(mMode), mMode == M_FAULT, mMode == M_CLEAN, mMode == M_TURN, mMode == M_FWD};
    check(tag, obs, exp);
    check({tag, "_onehot"}, 8'(int'(bus.avanca) + int'(bus.gira) + int'(bus.remove) <= 1), 8'd1);
  endtask

  // Drive one cycle of inputs at the falling edge, then advance model and check.
  task automatic applyStimulus(input bit rstN, input bit g, input bit h, input bit u,
                               input bit b, input string tag);
    @(negedge clk);
    reset       = rstN;
    bus.go      = g;
    bus.head    = h;
    bus.under   = u;
    bus.barrier = b;
    @(posedge clk);
    modelStep(rstN, g, h, u, b);
    #1;
    checkOutput(tag);
  endtask

  int cnt;

  initial begin
    reset = 1'b0; bus.go = 1'b1; bus.head = 1'b0; bus.under = 1'b1; bus.barrier = 1'b0;

    // 1: reset held with go=1, then release.
    applyStimulus(0, 1, 0, 1, 0, "rst0");
    applyStimulus(0, 1, 0, 1, 0, "rst1");
    check("rst_state", 8'(bus.state), 8'd0);
    check("rst_outs", {4'd0, bus.avanca, bus.gira, bus.remove, bus.fault}, 8'd0);
    applyStimulus(1, 1, 0, 1, 0, "release");
    check("release_avanca", 8'(bus.avanca), 8'd1);

    // 2: single-cycle obstacle gives exactly one turn attempt.
    applyStimulus(1, 1, 1, 1, 0, "t2_head");
    cnt = int'(bus.gira);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 0, 1, 0, "t2_run");
      cnt += int'(bus.gira);
    end
    check("t2_gira_cycles", 8'(cnt), 8'd4);
    check("t2_back_fwd", {4'd0, bus.state, bus.avanca}, {4'd0, 3'd1, 1'b1});

    // 3: obstacle never clears, three attempts then fault.
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 1, 1, 1, 0, "t3_run");
      cnt += int'(bus.gira);
    end
    check("t3_gira_cycles", 8'(cnt), 8'd12);
    check("t3_fault", {4'd0, bus.state, bus.fault}, {4'd0, 3'd4, 1'b1});

    // 4: barrier and obstacle together; cleaning wins.
    applyStimulus(0, 1, 0, 1, 0, "t4_rst");
    applyStimulus(1, 1, 0, 1, 0, "t4_fwd");
    applyStimulus(1, 1, 1, 1, 1, "t4_both");
    cnt = int'(bus.remove);
    check("t4_no_gira", 8'(bus.gira), 8'd0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, 1, 0, 1, 0, "t4_run");
      cnt += int'(bus.remove);
    end
    check("t4_remove_cycles", 8'(cnt), 8'd8);
    check("t4_back_fwd", 8'(bus.state), 8'd1);

    // 5: floor lost mid-clean, then restored: fault is sticky.
    applyStimulus(1, 1, 0, 1, 1, "t5_clean");
    applyStimulus(1, 1, 0, 1, 1, "t5_mid");
    applyStimulus(1, 1, 0, 0, 1, "t5_nofloor");
    check("t5_fault", 8'(bus.state), 8'd4);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 1, 0, "t5_sticky");
    check("t5_still_fault", 8'(bus.fault), 8'd1);

    // 6: operator stop mid-turn, then reset out of a fault.
    applyStimulus(0, 1, 0, 1, 0, "t6_rst");
    applyStimulus(1, 1, 0, 1, 0, "t6_fwd");
    applyStimulus(1, 1, 1, 1, 0, "t6_turn");
    applyStimulus(1, 1, 1, 1, 0, "t6_mid");
    applyStimulus(1, 0, 1, 1, 0, "t6_stop");
    check("t6_stop_state", 8'(bus.state), 8'd0);
    applyStimulus(1, 1, 0, 0, 0, "t6_tofault");
    check("t6_fault", 8'(bus.fault), 8'd1);
    applyStimulus(0, 1, 0, 0, 0, "t6_rstfault");
    check("t6_rst_clear", {4'd0, bus.state, bus.fault}, 8'd0);

    // Randomized soak against the model.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 99) >= 2,
                    $urandom_range(0, 99) < 92,
                    $urandom_range(0, 99) < 35,
                    $urandom_range(0, 99) < 98,
                    $urandom_range(0, 99) < 25,
                    "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
